rb_ser_wr: RTL
==============

# rb_ser_wr

Serial write front end for the 4×16-bit register bank. It deserialises framed bit-serial commands into one register write each, and drives the bank's `addr`, `data_in` and `valid_reg` inputs directly. It checks frame structure and an inactivity timeout, and keeps a saturating error count for debug.

## Interface
- `TIMEOUT`, default 64: number of consecutive cycles without `ser_en` after which an in-progress frame is aborted. Legal range is 2 to 65535.
- `clk_reg`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ser_in`  in  1  serial data bit. It is sampled only in cycles where `ser_en`=1.
- `ser_en`  in  1  bit strobe; one bit is consumed per cycle while `ser_en` is high.
- `addr`  out  2  register index of the last committed write.
- `data_in`  out  16  data of the last committed write.
- `valid_reg`  out  1  one-cycle write strobe to the register bank.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `err_cnt`  out  8  count of rejected frames; saturates at 255.

## Operation
- Frame format, in the order bits are sampled:
  - start bit = 0
  - `addr[1:0]`, MSB first
  - `data[15:0]`, MSB first
  - parity bit (only when `RB_SER_PARITY_EN` is defined)
  - stop bit = 1
- States are IDLE → ADDR → DATA → PAR → STOP → IDLE. PAR is skipped when parity is compiled out.
- IDLE:
  - A sampled 0 starts a frame and moves to ADDR.
  - A sampled 1 is line idle; stay in IDLE.
  - No timeout runs in IDLE.
- ADDR and DATA shift sampled bits into an internal shift register. A bit counter selects the next state after 2 and 16 bits respectively.
- PAR: the sampled bit must make the XOR of all 18 addr+data bits plus the parity bit equal 0 (even parity).
- STOP: the sampled bit must be 1.
- Commit happens when the stop bit is good and parity is good:
  - `addr` and `data_in` are loaded from the shift register.
  - `valid_reg`=1 for exactly one cycle.
  - `addr` and `data_in` then hold their values until the next commit.
- Reject happens on a bad stop bit, bad parity, or a timeout:
  - `frame_err` pulses for one cycle.
  - `err_cnt` increments, saturating at 255.
  - The FSM returns to IDLE.
  - `addr`, `data_in` and `valid_reg` are unchanged (no write is issued).
- Timeout:
  - An idle counter resets on every cycle with `ser_en`=1 and increments otherwise, in any state except IDLE.
  - Reaching `TIMEOUT` triggers a reject.
  - If a bit strobe arrives in the same cycle the timeout would fire, the bit wins: the bit is sampled and the counter clears.
- The output bus carries no backpressure; the bank accepts a write every cycle.

## Timing
- Reset values: `addr`=0, `data_in`=0, `valid_reg`=0, `busy`=0, `frame_err`=0, `err_cnt`=0. Reset also puts the FSM in IDLE and clears all counters.
- Reset asserted mid-frame discards the frame. No `valid_reg` and no `frame_err` are produced.
- Latency from the stop-bit sample edge:
  - `valid_reg`, `addr` and `data_in` are updated on the next rising edge, so they are registered with 1 cycle of latency.
  - `frame_err` follows the same timing.
- Timeout `frame_err` is asserted on the edge following the `TIMEOUT`-th consecutive idle cycle.
- `busy` rises the cycle after the start bit is sampled. It falls in the same cycle that `valid_reg` or `frame_err` is asserted.
- Back-to-back frames:
  - A start bit may be sampled in the cycle immediately after the stop bit.
  - The commit of frame N and the start of frame N+1 can overlap without loss.
- Minimum frame length is 20 strobes, or 21 with parity.

## Configuration
- `RB_SER_PARITY_EN`
  - Defined: the PAR state and the parity check exist; frames are 21 bits.
  - Undefined: no parity bit and no parity reject; frames are 20 bits.
  - `err_cnt` counts only stop and timeout errors when parity is compiled out.

## Test plan
- Reset, then one frame with `ser_en` held high: addr=2'b10, data=16'hA5C3, correct parity, stop=1. Expect `valid_reg` pulsed once, `addr`=2, `data_in`=16'hA5C3, `err_cnt`=0.
- Frame with stop bit 0. Expect `frame_err` pulse, `err_cnt`=1, no `valid_reg`, outputs still show the previous write.
- Parity build, frame with flipped parity bit. Expect reject and `err_cnt`+1. Non-parity build, same 20 addr/data/stop bits: expect commit.
- `ser_en` drops after 7 bits for `TIMEOUT`=64 cycles. Expect `frame_err` after cycle 64 and `busy`=0. Repeat with the strobe arriving exactly at cycle 64: the frame continues and commits.
- Four back-to-back frames writing 16'h0001 through 16'h0004 to addr 0 through 3. Expect exactly 4 `valid_reg` pulses in order. Then 300 bad frames: `err_cnt` saturates at 255.
- Assert `rst` at data bit 10. Expect no `valid_reg` or `frame_err`, all outputs 0. The next good frame commits normally.

Source files
------------

// File: rtl/rb_ser_wr.sv
// Serial write front end for the 4x16 register bank: framed bit-serial commands in, one bank write out.
// Optional parity bit is compiled in with `define RB_SER_PARITY_EN.
module rb_ser_wr #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_reg,
  input  logic        rst,
  input  logic        ser_in,
  input  logic        ser_en,
  output logic [1:0]  addr,
  output logic [15:0] data_in,
  output logic        valid_reg,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] sh_q, sh_d;
  logic [15:0] idle_q, idle_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic        reject;
`ifdef RB_SER_PARITY_EN
  logic        par_q, par_d;
  logic        pok_q, pok_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    idle_d  = idle_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    ecnt_d  = ecnt_q;
    reject  = 1'b0;
`ifdef RB_SER_PARITY_EN
    par_d   = par_q;
    pok_d   = pok_q;
`endif
    // A strobe in the cycle the timeout would fire takes priority.
    if (state_q != S_IDLE) begin
      if (ser_en)                          idle_d = 16'd0;
      else if (idle_q == 16'(TIMEOUT - 1)) reject = 1'b1;
      else                                 idle_d = idle_q + 16'd1;
    end
    if (ser_en) begin
      case (state_q)
        S_IDLE: if (!ser_in) begin
          state_d = S_ADDR;
          cnt_d   = 4'd0;
          idle_d  = 16'd0;
`ifdef RB_SER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
        S_ADDR, S_DATA: begin
          sh_d  = {sh_q[16:0], ser_in};
          cnt_d = cnt_q + 4'd1;
`ifdef RB_SER_PARITY_EN
          par_d = par_q ^ ser_in;
`endif
          if (state_q == S_ADDR && cnt_q == 4'd1) begin
            state_d = S_DATA;
            cnt_d   = 4'd0;
          end else if (state_q == S_DATA && cnt_q == 4'd15) begin
`ifdef RB_SER_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef RB_SER_PARITY_EN
        S_PAR: begin
          pok_d   = ~(par_q ^ ser_in);
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
`ifdef RB_SER_PARITY_EN
          if (ser_in && pok_q) begin
`else
          if (ser_in) begin
`endif
            addr_d  = sh_q[17:16];
            data_d  = sh_q[15:0];
            vld_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            reject = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (reject) begin
      state_d = S_IDLE;
      idle_d  = 16'd0;
      ferr_d  = 1'b1;
      if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_reg) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 18'd0;
      idle_q  <= 16'd0;
      addr_q  <= 2'd0;
      data_q  <= 16'd0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ecnt_q  <= 8'd0;
`ifdef RB_SER_PARITY_EN
      par_q   <= 1'b0;
      pok_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idle_q  <= idle_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ecnt_q  <= ecnt_d;
`ifdef RB_SER_PARITY_EN
      par_q   <= par_d;
      pok_q   <= pok_d;
`endif
    end
  end

  assign addr      = addr_q;
  assign data_in   = data_q;
  assign valid_reg = vld_q;
  assign frame_err = ferr_q;
  assign err_cnt   = ecnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
